// File: rtl/elevator_ctrl_n.sv
`timescale 1ns/1ps
// Parametrised N-floor elevator controller. Latches floor calls and serves them
// in SCAN order, times door dwell with hold inputs, and handles SOS/emergency.
module elevator_ctrl_n #(
   parameter int FLOORS     = 3,
   parameter int DOOR_TICKS = 5,
   parameter int MOVE_TICKS = 4,
   localparam int FLOOR_W   = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [FLOORS-1:0]  call_buttons,
   input  logic               keep_door_open_button,
   input  logic               presence_sensor,
   input  logic               weight_sensor,
   input  logic               sos_button,
   input  logic               okay,
   output logic [FLOORS-1:0]  floor_leds,
   output logic [FLOOR_W-1:0] current_floor,
   output logic               up_led,
   output logic               down_led,
   output logic               door_open,
   output logic               weight_led,
   output logic               sos_led,
   output logic               emergency_led
);

   localparam int MOVE_W = $clog2(MOVE_TICKS + 1);
   localparam int DOOR_W = $clog2(DOOR_TICKS + 1);

   typedef enum logic [1:0] {IDLE, MOVING, DOOR, EMERGENCY} state_t;

   state_t            state;
   logic              dir;       // 1 = up, 0 = down
   logic [FLOORS-1:0] req;
   logic [MOVE_W-1:0] move_cnt;
   logic [DOOR_W-1:0] door_cnt;

   function automatic logic [FLOORS-1:0] floors_beyond(input logic [FLOOR_W-1:0] f,
                                                      input logic up);
      logic [FLOORS-1:0] m;
      m = '0;
      for (int i = 0; i < FLOORS; i++)
         m[i] = up ? (i > int'(f)) : (i < int'(f));
      return m;
   endfunction

   function automatic logic [FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
      logic [FLOORS-1:0] m;
      m = '0;
      for (int i = 0; i < FLOORS; i++)
         m[i] = (i == int'(f));
      return m;
   endfunction

   logic [FLOOR_W-1:0] step_floor;
   logic [FLOORS-1:0]  cur_bit;
   logic [FLOORS-1:0]  step_bit;
   logic               ahead_now;
   logic               behind_now;
   logic               ahead_step;
   logic               hold;
   logic               step_done;

   assign step_floor = dir ? current_floor + 1'b1 : current_floor - 1'b1;
   assign cur_bit    = floor_bit(current_floor);
   assign step_bit   = floor_bit(step_floor);
   assign ahead_now  = |(req & floors_beyond(current_floor, dir));
   assign behind_now = |(req & floors_beyond(current_floor, ~dir));
   assign ahead_step = |(req & floors_beyond(step_floor, dir));
   // A call for the floor whose door is open re-opens the dwell instead of latching.
   assign hold       = keep_door_open_button | presence_sensor | weight_sensor |
                       (|(call_buttons & cur_bit));
   assign step_done  = (move_cnt == MOVE_W'(MOVE_TICKS - 1));
   assign floor_leds = req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         dir           <= 1'b1;
         req           <= '0;
         move_cnt      <= '0;
         door_cnt      <= '0;
         current_floor <= '0;
         up_led        <= 1'b0;
         down_led      <= 1'b0;
         door_open     <= 1'b0;
         weight_led    <= 1'b0;
         sos_led       <= 1'b0;
         emergency_led <= 1'b0;
      end else begin
         if (sos_button)
            sos_led <= 1'b1;
         case (state)
            IDLE: begin
               if (sos_button) begin
                  state         <= EMERGENCY;
                  req           <= '0;
                  door_open     <= 1'b1;
                  emergency_led <= 1'b1;
               end else if (|(req & cur_bit)) begin
                  req       <= (req | call_buttons) & ~cur_bit;
                  state     <= DOOR;
                  door_cnt  <= '0;
                  door_open <= 1'b1;
               end else begin
                  req <= req | call_buttons;
                  if (ahead_now) begin
                     state    <= MOVING;
                     move_cnt <= '0;
                     up_led   <= dir;
                     down_led <= ~dir;
                  end else if (behind_now) begin
                     dir      <= ~dir;
                     state    <= MOVING;
                     move_cnt <= '0;
                     up_led   <= ~dir;
                     down_led <= dir;
                  end
               end
            end
            MOVING: begin
               if (step_done) begin
                  move_cnt      <= '0;
                  current_floor <= step_floor;
                  // A pending SOS is honoured only once the carriage sits at a floor.
                  if (sos_button || sos_led) begin
                     state         <= EMERGENCY;
                     req           <= '0;
                     door_open     <= 1'b1;
                     emergency_led <= 1'b1;
                     up_led        <= 1'b0;
                     down_led      <= 1'b0;
                  end else if (|(req & step_bit)) begin
                     req       <= (req | call_buttons) & ~step_bit;
                     state     <= DOOR;
                     door_cnt  <= '0;
                     door_open <= 1'b1;
                     up_led    <= 1'b0;
                     down_led  <= 1'b0;
                  end else begin
                     req <= req | call_buttons;
                     if (!ahead_step) begin
                        state    <= IDLE;
                        up_led   <= 1'b0;
                        down_led <= 1'b0;
                     end
                  end
               end else begin
                  move_cnt <= move_cnt + 1'b1;
                  req      <= req | call_buttons;
               end
            end
            DOOR: begin
               if (sos_button) begin
                  state         <= EMERGENCY;
                  req           <= '0;
                  emergency_led <= 1'b1;
                  weight_led    <= 1'b0;
               end else begin
                  req <= req | (call_buttons & ~cur_bit);
                  if (hold) begin
                     door_cnt   <= '0;
                     weight_led <= weight_sensor;
                  end else if (door_cnt == DOOR_W'(DOOR_TICKS - 1)) begin
                     state      <= IDLE;
                     door_cnt   <= '0;
                     door_open  <= 1'b0;
                     weight_led <= 1'b0;
                  end else begin
                     door_cnt   <= door_cnt + 1'b1;
                     weight_led <= 1'b0;
                  end
               end
            end
            EMERGENCY: begin
               req <= '0;
               if (!sos_button && okay) begin
                  state         <= DOOR;
                  door_cnt      <= '0;
                  sos_led       <= 1'b0;
                  emergency_led <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
`timescale 1ns/1ps
// Bench for elevator_ctrl_n: directed scenarios plus random traffic, all checked
// against a phase/countdown model of the elevator behaviour.
module tb_elevator_ctrl_n;

   localparam int F  = 4;
   localparam int DT = 5;
   localparam int MT = 4;
   localparam int FW = 2;
   localparam int VW = F + FW + 6;
   localparam int PH_PARK = 0, PH_TRAVEL = 1, PH_DOORS = 2, PH_ALARM = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [F-1:0]  call_buttons = '0;
   logic          keep = 1'b0, pres = 1'b0, weight = 1'b0, sos = 1'b0, okay = 1'b0;
   logic [F-1:0]  floor_leds;
   logic [FW-1:0] current_floor;
   logic          up_led, down_led, door_open, weight_led, sos_led, emergency_led;
   logic [VW-1:0] dut_vec;

   int checks = 0;
   int failures = 0;

   // reference model state
   int           m_floor, m_phase, m_left;
   logic [F-1:0] m_req;
   bit           m_up, m_sos, m_wled;

   always #5 clk = ~clk;

   elevator_ctrl_n #(.FLOORS(F), .DOOR_TICKS(DT), .MOVE_TICKS(MT)) dut (
      .clk(clk), .rst_n(rst_n), .call_buttons(call_buttons),
      .keep_door_open_button(keep), .presence_sensor(pres), .weight_sensor(weight),
      .sos_button(sos), .okay(okay), .floor_leds(floor_leds),
      .current_floor(current_floor), .up_led(up_led), .down_led(down_led),
      .door_open(door_open), .weight_led(weight_led), .sos_led(sos_led),
      .emergency_led(emergency_led)
   );

   assign dut_vec = {floor_leds, current_floor, up_led, down_led, door_open,
                     weight_led, sos_led, emergency_led};

   function automatic bit beyond(input logic [F-1:0] r, input int f, input bit up);
      bit any;
      any = 0;
      for (int i = 0; i < F; i++)
         if (r[i] && (up ? (i > f) : (i < f))) any = 1;
      return any;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      return {m_req, FW'(m_floor), m_phase == PH_TRAVEL && m_up,
              m_phase == PH_TRAVEL && !m_up, m_phase == PH_DOORS || m_phase == PH_ALARM,
              m_wled, m_sos, m_phase == PH_ALARM};
   endfunction

   task automatic model_reset();
      m_floor = 0; m_phase = PH_PARK; m_left = 0; m_req = '0;
      m_up = 1; m_sos = 0; m_wled = 0;
   endtask

   task automatic enter_alarm();
      m_phase = PH_ALARM;
      m_req = '0;
   endtask

   // Advance the model by one clock using the inputs the DUT just sampled.
   task automatic model_step();
      logic [F-1:0] old, c;
      old = m_req;
      c = call_buttons;
      if (sos) m_sos = 1;
      m_wled = 0;
      case (m_phase)
         PH_PARK: begin
            m_req = old | c;
            if (sos) enter_alarm();
            else if (old[m_floor]) begin
               m_req[m_floor] = 1'b0; m_phase = PH_DOORS; m_left = DT;
            end else if (beyond(old, m_floor, m_up)) begin
               m_phase = PH_TRAVEL; m_left = MT;
            end else if (beyond(old, m_floor, !m_up)) begin
               m_up = !m_up; m_phase = PH_TRAVEL; m_left = MT;
            end
         end
         PH_TRAVEL: begin
            m_req = old | c;
            m_left--;
            if (m_left == 0) begin
               m_floor = m_up ? m_floor + 1 : m_floor - 1;
               if (m_sos) enter_alarm();
               else if (old[m_floor]) begin
                  m_req[m_floor] = 1'b0; m_phase = PH_DOORS; m_left = DT;
               end else if (!beyond(old, m_floor, m_up)) m_phase = PH_PARK;
               else m_left = MT;
            end
         end
         PH_DOORS: begin
            if (sos) enter_alarm();
            else begin
               c[m_floor] = 1'b0;
               m_req = old | c;
               if (keep || pres || weight || call_buttons[m_floor]) begin
                  m_left = DT; m_wled = weight;
               end else begin
                  m_left--;
                  if (m_left == 0) m_phase = PH_PARK;
               end
            end
         end
         default: begin
            m_req = '0;
            if (!sos && okay) begin
               m_phase = PH_DOORS; m_left = DT; m_sos = 0;
            end
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      call_buttons = '0; keep = 0; pres = 0; weight = 0; sos = 0; okay = 0;
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse_call(input logic [F-1:0] c);
      call_buttons = c;
      tick();
      call_buttons = '0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (dut_vec !== '0) begin
         failures++; $display("FAIL reset_outputs got=%h exp=0", dut_vec);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_run_top();
      int edge_at[F];
      int door_first, door_cycles;
      logic [F-1:0] leds_at_open;
      door_first = 0; door_cycles = 0; leds_at_open = 'x;
      for (int f = 0; f < F; f++) edge_at[f] = -1;
      apply_reset();
      pulse_call(4'b1000);
      for (int e = 2; e <= 24; e++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL run_top e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
         end
         if (e == 2) begin
            checks++;
            if (up_led !== 1'b1) begin
               failures++; $display("FAIL run_top_up_led got=%b exp=1", up_led);
            end
         end
         if (edge_at[current_floor] < 0) edge_at[current_floor] = e;
         if (door_open) begin
            door_cycles++;
            if (door_first == 0) begin
               door_first = e; leds_at_open = floor_leds;
            end
         end
      end
      for (int f = 1; f < F; f++) begin
         checks++;
         if (edge_at[f] != 2 + 4 * f) begin
            failures++; $display("FAIL run_top_floor%0d_edge got=%0d exp=%0d", f, edge_at[f], 2 + 4 * f);
         end
      end
      checks++;
      if (door_first != 14 || door_cycles != DT || leds_at_open !== '0) begin
         failures++;
         $display("FAIL run_top_door got=edge%0d/%0dcyc/leds%b exp=edge14/5cyc/leds0000",
                  door_first, door_cycles, leds_at_open);
      end
   endtask

   task automatic test_reverse();
      int served[$];
      bit prev_door, down_early, saw_down;
      prev_door = 0; down_early = 0; saw_down = 0;
      apply_reset();
      pulse_call(4'b0100);
      for (int n = 0; n < 20 && current_floor != 2'd1; n++) tick();
      checks++;
      if (current_floor !== 2'd1 || up_led !== 1'b1) begin
         failures++; $display("FAIL rev_reach_f1 got=%0d/up%b exp=1/up1", current_floor, up_led);
      end
      pulse_call(4'b0001);
      for (int n = 0; n < 60; n++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL rev n=%0d got=%h exp=%h", n, dut_vec, exp_vec());
         end
         if (door_open && !prev_door) served.push_back(int'(current_floor));
         if (down_led && served.size() == 0) down_early = 1;
         if (down_led) saw_down = 1;
         prev_door = door_open;
      end
      checks++;
      if (served.size() != 2) begin
         failures++; $display("FAIL rev_served_count got=%0d exp=2", served.size());
      end else if (served[0] != 2 || served[1] != 0) begin
         failures++; $display("FAIL rev_order got=%0d,%0d exp=2,0", served[0], served[1]);
      end
      checks++;
      if (down_early || !saw_down) begin
         failures++; $display("FAIL rev_down_led got=early%b/seen%b exp=early0/seen1", down_early, saw_down);
      end
   endtask

   task automatic open_door_at_2(input string tag);
      pulse_call(4'b0100);
      for (int n = 0; n < 30 && !door_open; n++) tick();
      checks++;
      if (door_open !== 1'b1 || current_floor !== 2'd2) begin
         failures++; $display("FAIL %s_open got=door%b/f%0d exp=door1/f2", tag, door_open, current_floor);
      end
   endtask

   task automatic test_door_hold();
      int close_n;
      close_n = 0;
      apply_reset();
      open_door_at_2("hold");
      pres = 1'b1;
      for (int n = 0; n < 10; n++) begin
         tick();
         checks++;
         if (door_open !== 1'b1 || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL hold_open n=%0d got=%h exp=%h", n, dut_vec, exp_vec());
         end
      end
      pres = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (!door_open && close_n == 0) close_n = n;
      end
      checks++;
      if (close_n != DT) begin
         failures++; $display("FAIL hold_close got=%0d exp=%0d", close_n, DT);
      end
   endtask

   task automatic test_weight();
      int close_n;
      bit saw_down;
      close_n = 0; saw_down = 0;
      apply_reset();
      open_door_at_2("weight");
      weight = 1'b1;
      pulse_call(4'b0001);
      for (int n = 0; n < 8; n++) begin
         tick();
         checks++;
         if (weight_led !== 1'b1 || door_open !== 1'b1 || current_floor !== 2'd2 ||
             dut_vec !== exp_vec()) begin
            failures++; $display("FAIL weight_hold n=%0d got=%h exp=%h", n, dut_vec, exp_vec());
         end
      end
      weight = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         tick();
         if (n == 1) begin
            checks++;
            if (weight_led !== 1'b0) begin
               failures++; $display("FAIL weight_led_release got=%b exp=0", weight_led);
            end
         end
         if (!door_open && close_n == 0) close_n = n;
         if (down_led) saw_down = 1;
      end
      checks++;
      if (close_n != DT || !saw_down) begin
         failures++; $display("FAIL weight_depart got=close%0d/down%b exp=close5/down1", close_n, saw_down);
      end
   endtask

   task automatic test_sos_mid_step();
      int close_n;
      close_n = 0;
      apply_reset();
      pulse_call(4'b1000);
      for (int n = 0; n < 20 && current_floor != 2'd1; n++) tick();
      tick();
      sos = 1'b1;
      tick();
      sos = 1'b0;
      for (int n = 0; n < 10 && !emergency_led; n++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL sos_step n=%0d got=%h exp=%h", n, dut_vec, exp_vec());
         end
      end
      checks++;
      if (emergency_led !== 1'b1 || current_floor !== 2'd2 || door_open !== 1'b1 ||
          floor_leds !== '0 || sos_led !== 1'b1 || up_led !== 1'b0) begin
         failures++; $display("FAIL sos_emergency got=%h exp=%h", dut_vec, {4'b0, 2'd2, 6'b001011});
      end
      call_buttons = 4'b1011;
      for (int n = 0; n < 4; n++) begin
         tick();
         checks++;
         if (floor_leds !== '0) begin
            failures++; $display("FAIL sos_calls_ignored got=%b exp=0000", floor_leds);
         end
      end
      call_buttons = '0;
      sos = 1'b1; okay = 1'b1;
      tick();
      checks++;
      if (emergency_led !== 1'b1 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL sos_beats_okay got=%h exp=%h", dut_vec, exp_vec());
      end
      sos = 1'b0;
      tick();
      okay = 1'b0;
      checks++;
      if (sos_led !== 1'b0 || emergency_led !== 1'b0 || door_open !== 1'b1) begin
         failures++; $display("FAIL sos_clear got=sos%b/em%b/door%b exp=sos0/em0/door1",
                              sos_led, emergency_led, door_open);
      end
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (!door_open && close_n == 0) close_n = n;
      end
      checks++;
      if (close_n != DT) begin
         failures++; $display("FAIL sos_door_close got=%0d exp=%0d", close_n, DT);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      pulse_call(4'b1000);
      for (int n = 0; n < 20 && current_floor != 2'd1; n++) tick();
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dut_vec !== '0) begin
         failures++; $display("FAIL async_reset got=%h exp=0", dut_vec);
      end
      @(posedge clk);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
         failures++; $display("FAIL async_reset_after got=%h exp=%h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int n = 0; n < 4000; n++) begin
         for (int b = 0; b < F; b++) call_buttons[b] = ($urandom_range(0, 19) == 0);
         keep   = ($urandom_range(0, 29) == 0);
         pres   = ($urandom_range(0, 29) == 0);
         weight = ($urandom_range(0, 39) == 0);
         sos    = ($urandom_range(0, 149) == 0);
         okay   = ($urandom_range(0, 7) == 0);
         tick();
         checks++;
         if (dut_vec !== exp_vec() || int'(current_floor) >= F) begin
            failures++; $display("FAIL random n=%0d got=%h exp=%h", n, dut_vec, exp_vec());
         end
      end
      call_buttons = '0; keep = 0; pres = 0; weight = 0; sos = 0; okay = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_run_top();
      test_reverse();
      test_door_hold();
      test_weight();
      test_sos_mid_step();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
